// File: rtl/rom_arb_pkg.sv
// Shared constants and helpers for the ROM round-robin arbiter.
package rom_arb_pkg;

    localparam int AW_DEF    = 4;
    localparam int DW_DEF    = 8;
    localparam int ROM_DEPTH = 16;

    // Ceiling log2, minimum 1 so a 2-requester id still has one bit.
    function automatic int clog2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) w++;
        return w;
    endfunction

    // Next round-robin pointer after a grant to requester p, wrapping at n.
    function automatic int rr_next(input int p, input int n);
        return (p + 1 >= n) ? 0 : p + 1;
    endfunction

endpackage

// File: rtl/rom_rr_arbiter_rr_pick.sv
// Combinational rotate-priority picker: first set req bit at or above ptr, modulo N.
module rr_pick #(
    parameter int N   = 3,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] winner
);

    // Walk the requesters starting at ptr; the first active one takes the grant.
    always_comb begin
        int  idx;
        logic found;
        gnt    = '0;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) idx = idx - N;
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                winner   = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/rom_rr_arbiter.sv
// Round-robin arbiter sharing one synchronous ROM among N requesters.
// One read issued per cycle; responses return tagged with the requester id
// 1+ROM_LAT cycles after the grant. Optional per-requester saturating grant
// counters are built when ROM_ARB_STATS_EN is defined.
module rom_rr_arbiter
    import rom_arb_pkg::*;
#(
    parameter  int N       = 3,
    parameter  int AW      = AW_DEF,
    parameter  int DW      = DW_DEF,
    parameter  int ROM_LAT = 1,
    localparam int IDW     = clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic [N*AW-1:0] req_addr,
    output logic [N-1:0]    gnt,
    output logic [AW-1:0]   rom_addr,
    input  logic [DW-1:0]   rom_data,
    output logic            rsp_valid,
    output logic [IDW-1:0]  rsp_id,
    output logic [DW-1:0]   rsp_data
`ifdef ROM_ARB_STATS_EN
    ,
    output logic [N*16-1:0] stat_grants
`endif
);

    logic [IDW-1:0]             ptr;
    logic [IDW-1:0]             winner;
    logic [N-1:0]               pick_gnt;
    logic                       any_gnt;
    logic [ROM_LAT:0]           vld_pipe;
    logic [ROM_LAT:0][IDW-1:0]  id_pipe;

    rr_pick #(.N(N), .IDW(IDW)) u_pick (
        .req    (req),
        .ptr    (ptr),
        .gnt    (pick_gnt),
        .winner (winner)
    );

    // Grants are suppressed while reset is held so nothing is accepted then.
    assign gnt     = rst ? '0 : pick_gnt;
    assign any_gnt = |gnt;

    // Pointer advances past the winner; holds when nobody is granted.
    always_ff @(posedge clk) begin
        if (rst)          ptr <= '0;
        else if (any_gnt) ptr <= IDW'(rr_next(int'(winner), N));
    end

    // Latch the winner's address toward the ROM at the grant edge.
    always_ff @(posedge clk) begin
        if (rst)          rom_addr <= '0;
        else if (any_gnt) rom_addr <= req_addr[int'(winner)*AW +: AW];
    end

    // Valid/id shift pipe matching ROM latency; reset drops in-flight reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            id_pipe  <= '0;
        end else begin
            vld_pipe <= {vld_pipe[ROM_LAT-1:0], any_gnt};
            id_pipe  <= {id_pipe[ROM_LAT-1:0], (any_gnt ? winner : IDW'(0))};
        end
    end

    assign rsp_valid = vld_pipe[ROM_LAT];
    assign rsp_id    = id_pipe[ROM_LAT];
    assign rsp_data  = rom_data;

`ifdef ROM_ARB_STATS_EN
    for (genvar i = 0; i < N; i++) begin : g_stat
        logic [15:0] cnt;
        // Count grants to requester i, sticking at all-ones.
        always_ff @(posedge clk) begin
            if (rst)                          cnt <= '0;
            else if (gnt[i] && cnt != 16'hFFFF) cnt <= cnt + 16'd1;
        end
        assign stat_grants[i*16 +: 16] = cnt;
    end
`endif

endmodule
